// File: rtl/mem_access_stage.sv
// MEM stage controller: drives the word-addressed data memory from the EX/MEM
// slot, handles sub-word loads/stores (stores via read-modify-write), blocks
// faulting accesses and owns the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 16,
  parameter int IDX_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        MemWriteSignal,
  output logic        MemReadSignal,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t state, state_nxt;

  // Captured read-modify-write context, consumed in RMW_WR
  logic [31:0]      merge_word_p1;
  logic [IDX_W-1:0] merge_idx_p1;
  logic [4:0]       merge_rd_p1;

  logic             mem_op, f3_illegal, misaligned, out_of_range, fault;
  logic             ok_load, ok_store, store_word, store_sub;
  logic [IDX_W-1:0] ex_idx;
  logic [31:0]      merged_word;

  // Lane select plus sign/zero extension for b/h/bu/hu; words pass through
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(word[{lo, 3'b000} +: 8]);
    h = $signed(lo[1] ? word[31:16] : word[15:0]);
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or half of the old word with the store data
  function automatic logic [31:0] merge_lane(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (f3[1:0] == 2'b00)
      r[{lo, 3'b000} +: 8] = wdata[7:0];
    else
      r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
    return r;
  endfunction

  assign mem_op       = ex_mem_read | ex_mem_write;
  assign f3_illegal   = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) ||
                        (ex_funct3 == 3'b111);
  assign misaligned   = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                        ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
  assign out_of_range = (ex_addr[31:2] >= DEPTH_L);
  assign fault        = ex_valid & mem_op &
                        ((ex_mem_read & ex_mem_write) | f3_illegal | misaligned | out_of_range);
  assign ok_load      = ex_valid & ex_mem_read  & ~fault;
  assign ok_store     = ex_valid & ex_mem_write & ~fault;
  assign store_word   = ok_store & (ex_funct3[1:0] == 2'b10);
  assign store_sub    = ok_store & ~store_word;
  assign ex_idx       = ex_addr[IDX_W+1:2];
  assign merged_word  = merge_lane(ex_funct3, ex_addr[1:0], MemReadData, ex_wdata);

  // State register; reset abandons any half-finished read-modify-write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a sub-word store spends one extra cycle writing the merge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (store_sub) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory enables and stall; everything held low while reset is asserted
  always_comb begin
    MemWriteSignal = 1'b0;
    MemReadSignal  = 1'b0;
    stall          = 1'b0;
    MemAddress     = {{(32-IDX_W){1'b0}}, ex_idx};
    MemWriteData   = ex_wdata;
    if (rst_n) begin
      case (state)
        IDLE: begin
          MemReadSignal  = ok_load | store_sub;
          MemWriteSignal = store_word;
          stall          = store_sub;
        end
        RMW_WR: begin
          MemWriteSignal = 1'b1;
          MemAddress     = {{(32-IDX_W){1'b0}}, merge_idx_p1};
          MemWriteData   = merge_word_p1;
        end
        default: ;
      endcase
    end
  end

  // Capture the merged word and its destination during the RMW read cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_word_p1 <= '0;
      merge_idx_p1  <= '0;
      merge_rd_p1   <= '0;
    end else if (state == IDLE && store_sub) begin
      merge_word_p1 <= merged_word;
      merge_idx_p1  <= ex_idx;
      merge_rd_p1   <= ex_rd;
    end
  end

  // MEM/WB register: load data, pass-through results, retire and fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_fault    <= 1'b0;
    end else if (state == RMW_WR) begin
      wb_valid     <= 1'b1;
      wb_reg_write <= 1'b0;
      wb_rd        <= merge_rd_p1;
      mem_fault    <= 1'b0;
    end else begin
      mem_fault <= fault;
      if (!ex_valid) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
      end else if (fault) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= 1'b0;
        wb_rd        <= ex_rd;
      end else if (ex_mem_read) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
        wb_rd        <= ex_rd;
        wb_data      <= load_extend(ex_funct3, ex_addr[1:0], MemReadData);
      end else if (ex_mem_write) begin
        wb_valid     <= store_word;
        wb_reg_write <= 1'b0;
        wb_rd        <= ex_rd;
      end else begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
        wb_rd        <= ex_rd;
        wb_data      <= ex_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 16-word behavioural data memory.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        MemWriteSignal, MemReadSignal, stall;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic        wb_valid, wb_reg_write, mem_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [31:0] mem [16];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;
  int          wr_count = 0;
  int          checks   = 0;
  int          failures = 0;
  int          wc0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH_WORDS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .MemWriteSignal(MemWriteSignal), .MemReadSignal(MemReadSignal),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemReadData(MemReadData),
    .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_fault(mem_fault)
  );

  assign MemReadData = (MemAddress < 32'd16) ? mem[MemAddress[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (MemWriteSignal) begin
      mem[MemAddress[3:0]] <= MemWriteData;
      wr_count <= wr_count + 1;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw);
    @(negedge clk);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, 5'd3, 1'b1);
    chk({tag, "_ren"}, 32'(MemReadSignal), 1);
    chk({tag, "_stall"}, 32'(stall), 0);
    @(posedge clk); #1;
    chk({tag, "_data"}, wb_data, exp);
  endtask

  task automatic fault_chk(input string tag, input logic [2:0] f3, input logic [31:0] a);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, 5'd9, 1'b1);
    chk({tag, "_en"}, {30'h0, MemReadSignal, MemWriteSignal}, 0);
    @(posedge clk); #1;
    chk({tag, "_flags"}, {29'h0, mem_fault, wb_valid, wb_reg_write}, 32'b110);
  endtask

  initial begin
    rst_n = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd = 0; ex_reg_write = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 4'(i);
      pre_data = (i == 1) ? 32'h11223344 : (i == 2) ? 32'h80FF7F01 : 32'(i);
    end
    @(negedge clk);
    pre_en = 1'b0;

    // Reset: enables gated even with a live load presented
    ex_valid = 1; ex_mem_read = 1; ex_addr = 32'h8; ex_funct3 = 3'b010;
    #1;
    chk("rst_enables", {29'h0, MemReadSignal, MemWriteSignal, stall}, 0);
    chk("rst_wb", {26'h0, wb_valid, wb_reg_write, mem_fault, wb_rd[2:0]}, 0);
    chk("rst_wb_data", wb_data, 0);
    ex_valid = 0; ex_mem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Sub-word and word loads from word 2 = 0x80FF7F01
    load_chk("lb8",  3'b000, 32'h8, 32'h00000001);
    chk("lb8_addr", MemAddress, 2);
    load_chk("lb9",  3'b000, 32'h9, 32'h0000007F);
    load_chk("lbA",  3'b000, 32'hA, 32'hFFFFFFFF);
    load_chk("lbuA", 3'b100, 32'hA, 32'h000000FF);
    load_chk("lhA",  3'b001, 32'hA, 32'hFFFF80FF);
    load_chk("lhuA", 3'b101, 32'hA, 32'h000080FF);
    chk("lhuA_rd", {27'h0, wb_rd}, 3);

    // sb@0xA: one stall cycle, then a single merged write
    wc0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'hA, 32'h123456AB, 5'd0, 1'b0);
    chk("sb_rd_cycle", {29'h0, stall, MemReadSignal, MemWriteSignal}, 32'b110);
    @(posedge clk); #1;
    chk("sb_bubble", 32'(wb_valid), 0);
    @(negedge clk); #1;
    chk("sb_wr_cycle", {29'h0, stall, MemReadSignal, MemWriteSignal}, 32'b001);
    chk("sb_wdata", MemWriteData, 32'h80AB7F01);
    chk("sb_waddr", MemAddress, 2);
    @(posedge clk); #1;
    chk("sb_retire", {30'h0, wb_valid, wb_reg_write}, 32'b10);
    chk("sb_wcount", 32'(wr_count - wc0), 1);
    load_chk("lw8_after_sb", 3'b010, 32'h8, 32'h80AB7F01);

    // sw then immediate lw to the same word
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'hC, 32'hDEADBEEF, 5'd0, 1'b0);
    chk("sw_en", {29'h0, stall, MemReadSignal, MemWriteSignal}, 32'b001);
    chk("sw_wdata", MemWriteData, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("sw_retire", {30'h0, wb_valid, wb_reg_write}, 32'b10);
    load_chk("lwC", 3'b010, 32'hC, 32'hDEADBEEF);

    // Faults: no enables, memory untouched
    wc0 = wr_count;
    fault_chk("f_lh9", 3'b001, 32'h9);
    fault_chk("f_lwA", 3'b010, 32'hA);
    fault_chk("f_f3_011", 3'b011, 32'h8);
    fault_chk("f_lw40", 3'b010, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("bubble_flags", {30'h0, mem_fault, wb_valid}, 0);
    chk("fault_nowrite", 32'(wr_count - wc0), 0);
    chk("fault_mem2", mem[2], 32'h80AB7F01);

    // Non-memory pass-through
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd7, 1'b1);
    @(posedge clk); #1;
    chk("alu_data", wb_data, 32'h55);
    chk("alu_ctl", {25'h0, wb_valid, wb_reg_write, wb_rd}, {25'h0, 2'b11, 5'd7});

    // sh@0x6 with reset dropped during the write cycle
    wc0 = wr_count;
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h6, 32'h0000BEEF, 5'd0, 1'b0);
    chk("sh_stall", 32'(stall), 1);
    @(posedge clk); #2;
    chk("sh_wr_cycle", 32'(MemWriteSignal), 1);
    chk("sh_wdata", MemWriteData, 32'hBEEF3344);
    rst_n = 1'b0;
    #1;
    chk("sh_rst_wen", {30'h0, MemWriteSignal, MemReadSignal}, 0);
    chk("sh_rst_wb", {26'h0, wb_valid, wb_reg_write, mem_fault, wb_rd[2:0]}, 0);
    chk("sh_rst_wb_data", wb_data, 0);
    @(posedge clk); #1;
    chk("sh_mem1", mem[1], 32'h11223344);
    chk("sh_nowrite", 32'(wr_count - wc0), 0);
    ex_valid = 0; ex_mem_write = 0;
    @(negedge clk);
    rst_n = 1'b1;
    load_chk("lw4_after_rst", 3'b010, 32'h4, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
